wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter driving the single write port of the processor register file. It merges results from three producers into one registered write per cycle. The producers are the single-cycle ALU path, the load/store unit (LSU) and the multiply/divide unit (MDU). The ALU has priority by default; LSU and MDU share the remaining slots round-robin and are protected from starvation by wait counters that can stall the ALU.

## Interface
Parameters:
- STARVE_MAX, 4: consecutive denied cycles after which a slow source overrides the ALU; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- alu_valid  in  1  ALU result present this cycle (no hold guarantee).
- alu_wa  in  5  ALU destination register.
- alu_wd  in  32  ALU result data.
- alu_stall  out  1  ALU result not consumed this cycle; pipeline must hold and re-present.
- lsu_valid  in  1  load result request; held with data stable until lsu_ready.
- lsu_ready  out  1  LSU granted this cycle.
- lsu_wa  in  5  load destination register.
- lsu_wd  in  32  load data.
- mdu_valid  in  1  MDU result request; held with data stable until mdu_ready.
- mdu_ready  out  1  MDU granted this cycle.
- mdu_wa  in  5  MDU destination register.
- mdu_wd  in  32  MDU result data.
- Wen  out  1  register file write enable (registered).
- Wa  out  5  register file write address (registered).
- Wd  out  32  register file write data (registered).

## Operation
- State: lsu_wait and mdu_wait counters, each 4 bits, saturating at STARVE_MAX; rr pointer, 1 bit (0 = LSU next, 1 = MDU next).
- A source is starved when its valid is 1 and its wait equals STARVE_MAX.
- Grant, evaluated combinationally each cycle, exactly one winner or none:
  - Any slow source starved: grant it. If both are starved, rr selects. alu_stall = alu_valid.
  - Else alu_valid: grant the ALU. alu_stall = 0.
  - Else one slow source valid: grant it. Both valid: rr selects.
  - Else no grant.
- lsu_ready and mdu_ready equal their grant bits. A transfer occurs on valid && ready. Ready is never asserted without valid.
- After any slow-source grant, rr points to the other slow source. ALU grants leave rr unchanged.
- Wait counters:
  - Clear when the source is granted or its valid is 0.
  - Otherwise increment, saturating at STARVE_MAX.
- Write-back register:
  - Wen <= granted && granted_wa != 0.
  - Wa and Wd <= the granted source's address and data whenever there is any grant, including Wa == 0.
  - When there is no grant, Wen <= 0 and Wa and Wd hold.
- Writes to register 0 are consumed (ready or grant asserted, counters cleared) but never enabled on Wen.
- Reset: Wen=0, Wa=0, Wd=0, rr=0, both counters 0. Combinational outputs follow from this state: alu_stall=0, and readys depend only on the inputs.
- Reset mid-operation: counters and rr clear in the same edge, and any in-flight grant of that cycle is discarded (Wen=0 next cycle). The slow-source handshake restarts; sources keep valid asserted.

## Timing
- Grant, ready and alu_stall are combinational from valids and registered state in the same cycle.
- Write latency is 1 cycle. A winner in cycle N appears on Wen/Wa/Wd in cycle N+1, and is readable from the register file in cycle N+2.
- Throughput is one write per cycle; no bubbles are inserted between back-to-back grants.
- Worst-case slow-source wait with continuous ALU traffic is STARVE_MAX cycles.
  - With both slow sources starving, the second one is granted on the following cycle.
- Registered outputs only change on the clk rising edge; no combinational path from inputs to Wen/Wa/Wd.

## Test plan
- Reset, then 3 cycles idle: Wen=0, Wa=0, Wd=0, alu_stall=0, lsu_ready=mdu_ready=0 every cycle.
- alu_valid=1, alu_wa=5, alu_wd=0xDEADBEEF for one cycle: next cycle Wen=1, Wa=5, Wd=0xDEADBEEF; the following cycle Wen=0 and Wa/Wd hold.
- lsu_valid and mdu_valid held high from reset (wa=3/4, distinct data), no ALU traffic:
  - LSU is granted first, then MDU.
  - Wen pulses on 2 consecutive cycles with Wa=3 then Wa=4.
- alu_valid=1 continuously, lsu_valid=1 from cycle 0, STARVE_MAX=4:
  - lsu_ready=0 for cycles 0-3.
  - Cycle 4: lsu_ready=1, alu_stall=1.
  - Cycle 5: Wa = LSU address, and ALU grants resume.
- mdu_valid with mdu_wa=0, data 0x1234: mdu_ready=1 in that cycle, Wen stays 0 next cycle, mdu_wait cleared.
- LSU starved (wait=4) and rst pulsed for 1 cycle: next cycle Wen=0, counters 0, ALU wins again, and the LSU needs 4 further denied cycles before its override.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Bundle of the three producer result ports and the register-file write port.
// The arbiter sits on the slave side; producers and the register file sit on the master side.
interface wb_arbiter_if;
    logic        alu_valid;
    logic [4:0]  alu_wa;
    logic [31:0] alu_wd;
    logic        alu_stall;

    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_wa;
    logic [31:0] lsu_wd;

    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_wa;
    logic [31:0] mdu_wd;

    logic        Wen;
    logic [4:0]  Wa;
    logic [31:0] Wd;

    modport slave (
        input  alu_valid, alu_wa, alu_wd,
        input  lsu_valid, lsu_wa, lsu_wd,
        input  mdu_valid, mdu_wa, mdu_wd,
        output alu_stall, lsu_ready, mdu_ready,
        output Wen, Wa, Wd
    );

    modport master (
        output alu_valid, alu_wa, alu_wd,
        output lsu_valid, lsu_wa, lsu_wd,
        output mdu_valid, mdu_wa, mdu_wd,
        input  alu_stall, lsu_ready, mdu_ready,
        input  Wen, Wa, Wd
    );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU-first priority, LSU/MDU round-robin, with wait counters
// that let a slow source override the ALU after STARVE_MAX denied cycles.
module wb_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);

    localparam logic [3:0] WAIT_LIM = 4'(STARVE_MAX);

    logic [3:0]  lsu_wait_q, lsu_wait_d;
    logic [3:0]  mdu_wait_q, mdu_wait_d;
    logic        rr_q, rr_d;
    logic        wen_q, wen_d;
    logic [4:0]  wa_q, wa_d;
    logic [31:0] wd_q, wd_d;

    logic lsu_starved, mdu_starved;
    logic grant_alu, grant_lsu, grant_mdu;

    assign lsu_starved = bus.lsu_valid && (lsu_wait_q == WAIT_LIM);
    assign mdu_starved = bus.mdu_valid && (mdu_wait_q == WAIT_LIM);

    always_comb begin
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        grant_mdu = 1'b0;
        if (lsu_starved && mdu_starved) begin
            grant_lsu = !rr_q;
            grant_mdu = rr_q;
        end else if (lsu_starved) begin
            grant_lsu = 1'b1;
        end else if (mdu_starved) begin
            grant_mdu = 1'b1;
        end else if (bus.alu_valid) begin
            grant_alu = 1'b1;
        end else if (bus.lsu_valid && bus.mdu_valid) begin
            grant_lsu = !rr_q;
            grant_mdu = rr_q;
        end else begin
            grant_lsu = bus.lsu_valid;
            grant_mdu = bus.mdu_valid;
        end
    end

    assign bus.alu_stall = bus.alu_valid && !grant_alu;
    assign bus.lsu_ready = grant_lsu;
    assign bus.mdu_ready = grant_mdu;

    always_comb begin
        rr_d       = rr_q;
        lsu_wait_d = lsu_wait_q;
        mdu_wait_d = mdu_wait_q;
        wen_d      = 1'b0;
        wa_d       = wa_q;
        wd_d       = wd_q;

        if (grant_lsu)      rr_d = 1'b1;
        else if (grant_mdu) rr_d = 1'b0;

        if (grant_lsu || !bus.lsu_valid)  lsu_wait_d = 4'd0;
        else if (lsu_wait_q != WAIT_LIM)  lsu_wait_d = lsu_wait_q + 4'd1;

        if (grant_mdu || !bus.mdu_valid)  mdu_wait_d = 4'd0;
        else if (mdu_wait_q != WAIT_LIM)  mdu_wait_d = mdu_wait_q + 4'd1;

        // Register 0 writes are consumed but never enabled; address/data still update.
        if (grant_alu) begin
            wa_d = bus.alu_wa;
            wd_d = bus.alu_wd;
        end else if (grant_lsu) begin
            wa_d = bus.lsu_wa;
            wd_d = bus.lsu_wd;
        end else if (grant_mdu) begin
            wa_d = bus.mdu_wa;
            wd_d = bus.mdu_wd;
        end
        if (grant_alu || grant_lsu || grant_mdu) wen_d = (wa_d != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lsu_wait_q <= 4'd0;
            mdu_wait_q <= 4'd0;
            rr_q       <= 1'b0;
            wen_q      <= 1'b0;
            wa_q       <= 5'd0;
            wd_q       <= 32'd0;
        end else begin
            lsu_wait_q <= lsu_wait_d;
            mdu_wait_q <= mdu_wait_d;
            rr_q       <= rr_d;
            wen_q      <= wen_d;
            wa_q       <= wa_d;
            wd_q       <= wd_d;
        end
    end

    assign bus.Wen = wen_q;
    assign bus.Wa  = wa_q;
    assign bus.Wd  = wd_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with STARVE_MAX=4; expected values are hand-computed.
module tb_wb_arbiter;

    logic clk;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    wb_arbiter_if bus ();

    wb_arbiter #(.STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wb(input string tag, input logic wen, input logic [4:0] wa, input logic [31:0] wd);
        chk({tag, "_wen"}, 32'(bus.Wen), 32'(wen));
        chk({tag, "_wa"},  32'(bus.Wa),  32'(wa));
        chk({tag, "_wd"},  bus.Wd,       wd);
    endtask

    task automatic chk_comb(input string tag, input logic stall, input logic lrdy, input logic mrdy);
        chk({tag, "_alu_stall"}, 32'(bus.alu_stall), 32'(stall));
        chk({tag, "_lsu_ready"}, 32'(bus.lsu_ready), 32'(lrdy));
        chk({tag, "_mdu_ready"}, 32'(bus.mdu_ready), 32'(mrdy));
    endtask

    initial begin
        rst = 1'b1;
        bus.alu_valid = 1'b0; bus.alu_wa = 5'd0; bus.alu_wd = 32'd0;
        bus.lsu_valid = 1'b0; bus.lsu_wa = 5'd0; bus.lsu_wd = 32'd0;
        bus.mdu_valid = 1'b0; bus.mdu_wa = 5'd0; bus.mdu_wd = 32'd0;
        tick();
        tick();
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_wb("idle", 1'b0, 5'd0, 32'd0);
            chk_comb("idle", 1'b0, 1'b0, 1'b0);
            tick();
        end

        // Single ALU write, then hold
        bus.alu_valid = 1'b1; bus.alu_wa = 5'd5; bus.alu_wd = 32'hDEADBEEF;
        #1;
        chk_comb("alu", 1'b0, 1'b0, 1'b0);
        tick();
        bus.alu_valid = 1'b0;
        chk_wb("alu_wr", 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        chk_wb("alu_hold", 1'b0, 5'd5, 32'hDEADBEEF);

        // Both slow sources, no ALU: LSU first (rr=0), then MDU, then LSU's second request
        bus.lsu_valid = 1'b1; bus.lsu_wa = 5'd3; bus.lsu_wd = 32'h33333333;
        bus.mdu_valid = 1'b1; bus.mdu_wa = 5'd4; bus.mdu_wd = 32'h44444444;
        #1;
        chk_comb("rr0", 1'b0, 1'b1, 1'b0);
        tick();
        bus.lsu_wa = 5'd6; bus.lsu_wd = 32'h66666666;
        #1;
        chk_wb("rr0_wr", 1'b1, 5'd3, 32'h33333333);
        chk_comb("rr1", 1'b0, 1'b0, 1'b1);
        tick();
        bus.mdu_valid = 1'b0;
        #1;
        chk_wb("rr1_wr", 1'b1, 5'd4, 32'h44444444);
        chk_comb("rr2", 1'b0, 1'b1, 1'b0);
        tick();
        bus.lsu_valid = 1'b0;
        chk_wb("rr2_wr", 1'b1, 5'd6, 32'h66666666);
        tick();
        chk_wb("rr_idle", 1'b0, 5'd6, 32'h66666666);

        // LSU starvation under continuous ALU traffic
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_wa = 5'd7; bus.alu_wd = 32'hA1A1A1A1;
        bus.lsu_valid = 1'b1; bus.lsu_wa = 5'd9; bus.lsu_wd = 32'h99999999;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk_comb("starve_deny", 1'b0, 1'b0, 1'b0);
            tick();
            chk_wb("starve_alu_wr", 1'b1, 5'd7, 32'hA1A1A1A1);
        end
        chk_comb("starve_grant", 1'b1, 1'b1, 1'b0);
        tick();
        bus.lsu_valid = 1'b0;
        #1;
        chk_wb("starve_lsu_wr", 1'b1, 5'd9, 32'h99999999);
        chk_comb("starve_resume", 1'b0, 1'b0, 1'b0);
        tick();
        chk_wb("starve_alu_again", 1'b1, 5'd7, 32'hA1A1A1A1);

        // Reset while LSU is starved discards the override and restarts the wait
        bus.lsu_valid = 1'b1; bus.lsu_wa = 5'd10; bus.lsu_wd = 32'hAAAA0000;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk_comb("pre_rst_deny", 1'b0, 1'b0, 1'b0);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_wb("mid_rst", 1'b0, 5'd0, 32'd0);
        chk("mid_rst_lsu_wait", 32'(dut.lsu_wait_q), 32'd0);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk_comb("post_rst_deny", 1'b0, 1'b0, 1'b0);
            tick();
            chk_wb("post_rst_alu_wr", 1'b1, 5'd7, 32'hA1A1A1A1);
        end
        chk_comb("post_rst_grant", 1'b1, 1'b1, 1'b0);
        tick();
        bus.lsu_valid = 1'b0;
        chk_wb("post_rst_lsu_wr", 1'b1, 5'd10, 32'hAAAA0000);

        // Both starved with ALU busy: rr=1 after last LSU grant, so MDU first, LSU next cycle
        bus.lsu_valid = 1'b1; bus.lsu_wa = 5'd11; bus.lsu_wd = 32'hBBBBBBBB;
        bus.mdu_valid = 1'b1; bus.mdu_wa = 5'd12; bus.mdu_wd = 32'hCCCCCCCC;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk_comb("both_deny", 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk_comb("both_first", 1'b1, 1'b0, 1'b1);
        tick();
        bus.mdu_valid = 1'b0;
        #1;
        chk_wb("both_mdu_wr", 1'b1, 5'd12, 32'hCCCCCCCC);
        chk_comb("both_second", 1'b1, 1'b1, 1'b0);
        tick();
        bus.lsu_valid = 1'b0;
        #1;
        chk_wb("both_lsu_wr", 1'b1, 5'd11, 32'hBBBBBBBB);
        chk_comb("both_alu_back", 1'b0, 1'b0, 1'b0);
        tick();
        chk_wb("both_alu_wr", 1'b1, 5'd7, 32'hA1A1A1A1);

        // MDU write to r0: consumed, wait cleared, never enabled
        bus.mdu_valid = 1'b1; bus.mdu_wa = 5'd0; bus.mdu_wd = 32'h00001234;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk_comb("r0_deny", 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk("r0_wait_before", 32'(dut.mdu_wait_q), 32'd2);
        bus.alu_valid = 1'b0;
        #1;
        chk_comb("r0_grant", 1'b0, 1'b0, 1'b1);
        tick();
        bus.mdu_valid = 1'b0;
        chk_wb("r0_wr", 1'b0, 5'd0, 32'h00001234);
        chk("r0_wait_clear", 32'(dut.mdu_wait_q), 32'd0);
        tick();
        chk_wb("final_idle", 1'b0, 5'd0, 32'h00001234);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
